// File: rtl/key_mode_ctrl.sv
// Key-driven mode controller for a clock/alarm: RUN / SET_TIME / SET_ALARM editing,
// commit strobes for the time base, alarm registers, idle timeout and field blinking.
module key_mode_ctrl #(
    parameter int TIMEOUT_S = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_pulse,
    input  logic       tick_1hz,
    input  logic [4:0] time_hour,
    input  logic [5:0] time_min,
    input  logic [5:0] time_sec,
    output logic [1:0] mode,
    output logic [1:0] field_sel,
    output logic [4:0] edit_hour,
    output logic [5:0] edit_min,
    output logic [5:0] edit_sec,
    output logic       time_load,
    output logic [4:0] load_hour,
    output logic [5:0] load_min,
    output logic [5:0] load_sec,
    output logic [4:0] alarm_hour,
    output logic [5:0] alarm_min,
    output logic       alarm_en,
    output logic [2:0] blink_hide
);

    typedef enum logic [1:0] {
        MODE_RUN       = 2'd0,
        MODE_SET_TIME  = 2'd1,
        MODE_SET_ALARM = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        FIELD_HOUR = 2'd0,
        FIELD_MIN  = 2'd1,
        FIELD_SEC  = 2'd2
    } field_e;

    localparam int              CNT_W    = $clog2(TIMEOUT_S + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_S - 1);

    mode_e            state;
    field_e           field;
    logic             phase;
    logic [CNT_W-1:0] idle_cnt;

    // Only the highest-priority pressed key acts; the rest of the same cycle is dropped.
    logic key_mode, key_sel, key_inc, key_dec, any_key;
    assign key_mode = key_pulse[0];
    assign key_sel  = key_pulse[1] & ~key_pulse[0];
    assign key_inc  = key_pulse[2] & ~|key_pulse[1:0];
    assign key_dec  = key_pulse[3] & ~|key_pulse[2:0];
    assign any_key  = |key_pulse;

    function automatic logic [5:0] wrap_step(input logic [5:0] v, input logic [5:0] max_v,
                                             input logic up);
        if (up) return (v == max_v) ? 6'd0 : v + 6'd1;
        else    return (v == 6'd0)  ? max_v : v - 6'd1;
    endfunction

    assign mode      = state;
    assign field_sel = field;

    always_comb begin
        blink_hide = 3'b000;
        if (state != MODE_RUN && phase) begin
            case (field)
                FIELD_HOUR: blink_hide = 3'b001;
                FIELD_MIN:  blink_hide = 3'b010;
                FIELD_SEC:  blink_hide = 3'b100;
                default:    blink_hide = 3'b000;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order within this block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= MODE_RUN;
            field      <= FIELD_HOUR;
            phase      <= 1'b0;
            idle_cnt   <= '0;
            edit_hour  <= '0;
            edit_min   <= '0;
            edit_sec   <= '0;
            time_load  <= 1'b0;
            load_hour  <= '0;
            load_min   <= '0;
            load_sec   <= '0;
            alarm_hour <= '0;
            alarm_min  <= '0;
            alarm_en   <= 1'b0;
        end else begin
            time_load <= 1'b0;

            if (any_key)       phase <= 1'b0;
            else if (tick_1hz) phase <= ~phase;

            if (state == MODE_RUN) begin
                idle_cnt <= '0;
                if (key_mode) begin
                    state     <= MODE_SET_TIME;
                    field     <= FIELD_HOUR;
                    edit_hour <= time_hour;
                    edit_min  <= time_min;
                    edit_sec  <= time_sec;
                end else if (key_sel) begin
                    alarm_en <= ~alarm_en;
                end
            end else if (any_key) begin
                idle_cnt <= '0;
                if (key_mode) begin
                    if (state == MODE_SET_TIME) begin
                        time_load <= 1'b1;
                        load_hour <= edit_hour;
                        load_min  <= edit_min;
                        load_sec  <= edit_sec;
                        edit_hour <= alarm_hour;
                        edit_min  <= alarm_min;
                        edit_sec  <= '0;
                        field     <= FIELD_HOUR;
                        state     <= MODE_SET_ALARM;
                    end else begin
                        alarm_hour <= edit_hour;
                        alarm_min  <= edit_min;
                        state      <= MODE_RUN;
                    end
                end else if (key_sel) begin
                    if (state == MODE_SET_TIME) begin
                        case (field)
                            FIELD_HOUR: field <= FIELD_MIN;
                            FIELD_MIN:  field <= FIELD_SEC;
                            default:    field <= FIELD_HOUR;
                        endcase
                    end else begin
                        field <= (field == FIELD_HOUR) ? FIELD_MIN : FIELD_HOUR;
                    end
                end else begin
                    case (field)
                        FIELD_HOUR: edit_hour <= 5'(wrap_step({1'b0, edit_hour}, 6'd23, key_inc));
                        FIELD_MIN:  edit_min  <= wrap_step(edit_min, 6'd59, key_inc);
                        FIELD_SEC:  edit_sec  <= wrap_step(edit_sec, 6'd59, key_inc);
                        default:    ;
                    endcase
                end
            end else if (tick_1hz) begin
                // Abandon the edit silently: no commit, no alarm update.
                if (idle_cnt == CNT_LAST) begin
                    state    <= MODE_RUN;
                    idle_cnt <= '0;
                end else begin
                    idle_cnt <= idle_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_key_mode_ctrl.sv
// Directed self-checking bench for key_mode_ctrl: edit/commit flow, wraps, timeout,
// key priority and reset behaviour, with hand-computed expectations.
module tb_key_mode_ctrl;

    localparam logic [3:0] K_NONE = 4'b0000;
    localparam logic [3:0] K_MODE = 4'b0001;
    localparam logic [3:0] K_SEL  = 4'b0010;
    localparam logic [3:0] K_INC  = 4'b0100;
    localparam logic [3:0] K_DEC  = 4'b1000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key_pulse = '0;
    logic       tick_1hz = 1'b0;
    logic [4:0] time_hour = '0;
    logic [5:0] time_min = '0;
    logic [5:0] time_sec = '0;
    logic [1:0] mode, field_sel;
    logic [4:0] edit_hour, load_hour, alarm_hour;
    logic [5:0] edit_min, edit_sec, load_min, load_sec, alarm_min;
    logic       time_load, alarm_en;
    logic [2:0] blink_hide;

    int checks = 0;
    int failures = 0;
    logic seen_load;

    key_mode_ctrl #(.TIMEOUT_S(30)) dut (
        .clk(clk), .rst(rst), .key_pulse(key_pulse), .tick_1hz(tick_1hz),
        .time_hour(time_hour), .time_min(time_min), .time_sec(time_sec),
        .mode(mode), .field_sel(field_sel),
        .edit_hour(edit_hour), .edit_min(edit_min), .edit_sec(edit_sec),
        .time_load(time_load), .load_hour(load_hour), .load_min(load_min), .load_sec(load_sec),
        .alarm_hour(alarm_hour), .alarm_min(alarm_min), .alarm_en(alarm_en),
        .blink_hide(blink_hide)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Apply inputs for one rising edge, then sample 1 ns after it.
    task automatic step(input logic [3:0] k, input logic t);
        key_pulse = k;
        tick_1hz  = t;
        @(posedge clk);
        #1;
        key_pulse = '0;
        tick_1hz  = 1'b0;
    endtask

    task automatic check_all_reset(input string tag);
        check({tag, "_mode"}, mode, 0);
        check({tag, "_field"}, field_sel, 0);
        check({tag, "_edit"}, {edit_hour, edit_min, edit_sec}, 0);
        check({tag, "_load"}, {load_hour, load_min, load_sec}, 0);
        check({tag, "_tload"}, time_load, 0);
        check({tag, "_alarm"}, {alarm_hour, alarm_min, alarm_en}, 0);
        check({tag, "_blink"}, blink_hide, 0);
    endtask

    initial begin
        // Reset, with a coincident MODE and tick that must be ignored.
        rst = 1'b1;
        step(K_MODE, 1'b1);
        check_all_reset("rst0");
        rst = 1'b0;
        step(K_NONE, 1'b0);
        check("rst0_hold_mode", mode, 0);

        // 12:34:56 -> SET_TIME, minute +26 wraps to 00, commit.
        time_hour = 5'd12; time_min = 6'd34; time_sec = 6'd56;
        step(K_MODE, 1'b0);
        check("enter_set_mode", mode, 1);
        check("enter_set_edit", {edit_hour, edit_min, edit_sec}, {5'd12, 6'd34, 6'd56});
        check("enter_set_field", field_sel, 0);
        step(K_SEL, 1'b0);
        check("sel_min", field_sel, 1);
        for (int i = 0; i < 26; i++) step(K_INC, 1'b0);
        check("min_wrap", {edit_hour, edit_min, edit_sec}, {5'd12, 6'd0, 6'd56});
        step(K_MODE, 1'b0);
        check("commit_tload", time_load, 1);
        check("commit_load", {load_hour, load_min, load_sec}, {5'd12, 6'd0, 6'd56});
        check("commit_mode", mode, 2);
        check("alarm_edit_init", {edit_hour, edit_min, edit_sec, field_sel}, 0);
        step(K_NONE, 1'b0);
        check("tload_one_cycle", time_load, 0);

        // SET_ALARM: hour +7, minute 0-1 wraps to 59, store on MODE.
        for (int i = 0; i < 7; i++) step(K_INC, 1'b0);
        check("alarm_hour_inc", edit_hour, 7);
        step(K_SEL, 1'b0);
        check("alarm_sel_min", field_sel, 1);
        step(K_DEC, 1'b0);
        check("alarm_min_wrap", edit_min, 59);
        step(K_SEL, 1'b0);
        check("alarm_sel_back", field_sel, 0);
        step(K_MODE, 1'b0);
        check("alarm_store", {alarm_hour, alarm_min}, {5'd7, 6'd59});
        check("alarm_exit_mode", mode, 0);
        check("alarm_no_tload", time_load, 0);

        // SET_TIME with hour 0: DEC wraps to 23; field cycling and blink.
        time_hour = 5'd0; time_min = 6'd10; time_sec = 6'd20;
        step(K_MODE, 1'b0);
        step(K_DEC, 1'b0);
        check("hour_dec_wrap", edit_hour, 23);
        step(K_NONE, 1'b1);
        check("blink_hour", blink_hide, 3'b001);
        step(K_SEL, 1'b0);
        check("sel1_field", field_sel, 1);
        check("blink_cleared", blink_hide, 0);
        step(K_NONE, 1'b1);
        check("blink_min", blink_hide, 3'b010);
        step(K_SEL, 1'b0);
        check("sel2_field", field_sel, 2);
        step(K_SEL, 1'b0);
        check("sel3_field", field_sel, 0);

        // Timeout: key on the 29th tick restarts the count; 30 quiet ticks return to RUN.
        seen_load = 1'b0;
        for (int i = 0; i < 28; i++) begin
            step(K_NONE, 1'b1);
            seen_load |= time_load;
        end
        check("to_before_key", mode, 1);
        step(K_INC, 1'b1);
        check("to_key_wins_mode", mode, 1);
        check("to_key_wins_inc", edit_hour, 0);
        for (int i = 0; i < 29; i++) begin
            step(K_NONE, 1'b1);
            seen_load |= time_load;
        end
        check("to_29_ticks", mode, 1);
        step(K_NONE, 1'b1);
        seen_load |= time_load;
        check("to_30th_tick", mode, 0);
        check("to_no_tload", seen_load, 0);
        check("to_alarm_kept", {alarm_hour, alarm_min}, {5'd7, 6'd59});
        check("to_load_kept", {load_hour, load_min, load_sec}, {5'd12, 6'd0, 6'd56});
        step(K_NONE, 1'b1);
        check("run_blink_off", blink_hide, 0);

        // Priority: 1101 in SET_TIME performs only MODE.
        time_hour = 5'd5; time_min = 6'd6; time_sec = 6'd7;
        step(K_MODE, 1'b0);
        step(4'b1101, 1'b0);
        check("prio_mode", mode, 2);
        check("prio_tload", time_load, 1);
        check("prio_load", {load_hour, load_min, load_sec}, {5'd5, 6'd6, 6'd7});
        check("prio_edit", {edit_hour, edit_min, edit_sec}, {5'd7, 6'd59, 6'd0});
        step(K_MODE, 1'b0);
        check("prio_back_run", mode, 0);
        step(K_INC, 1'b0);
        check("run_inc_ignored", {mode, edit_hour}, {2'd0, 5'd7});
        check("alarm_en_before", alarm_en, 0);
        step(K_SEL, 1'b0);
        check("alarm_en_toggle", alarm_en, 1);

        // Reset mid-edit with a coincident MODE pulse.
        step(K_MODE, 1'b0);
        step(K_INC, 1'b0);
        check("pre_rst_edit", {mode, edit_hour}, {2'd1, 5'd6});
        rst = 1'b1;
        step(K_MODE, 1'b0);
        check_all_reset("rst1");
        rst = 1'b0;
        step(K_NONE, 1'b0);
        check("rst1_after_tload", time_load, 0);
        check("rst1_after_mode", mode, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/key_mode_ctrl.md
KEY_MODE_CTRL -- requirements
Module: key_mode_ctrl

Interface
REQ-001 Parameter: TIMEOUT_S, default 30, number of tick_1hz pulses without a key press before a set mode is abandoned.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 key_pulse  input  4  one-cycle press strobes from the debounce stage, bit mapping below.
- [0] MODE
- [1] SELECT
- [2] INC
- [3] DEC
REQ-005 tick_1hz  input  1  one-cycle strobe once per second.
REQ-006 time_hour  input  5  current time hour (0-23), captured on entering SET_TIME.
REQ-007 time_min  input  6  current time minute (0-59).
REQ-008 time_sec  input  6  current time second (0-59).
REQ-009 mode  output  2  0=RUN, 1=SET_TIME, 2=SET_ALARM.
REQ-010 field_sel  output  2  0=HOUR, 1=MIN, 2=SEC.
REQ-011 edit_hour  output  5  edit value for hour.
REQ-012 edit_min  output  6  edit value for minute.
REQ-013 edit_sec  output  6  edit value for second.
REQ-014 time_load  output  1  one-cycle commit strobe; load_hour/min/sec valid when high.
REQ-015 load_hour  output  5  committed hour, valid with time_load.
REQ-016 load_min  output  6  committed minute, valid with time_load.
REQ-017 load_sec  output  6  committed second, valid with time_load.
REQ-018 alarm_hour  output  5  registered alarm hour.
REQ-019 alarm_min  output  6  registered alarm minute.
REQ-020 alarm_en  output  1  registered alarm enable.
REQ-021 blink_hide  output  3  one-hot display blank for the field being edited: [0]=hour, [1]=min, [2]=sec.

Function
REQ-022 Key priority: MODE > SELECT > INC > DEC; each cycle only the highest-priority set bit SHALL act and the others SHALL be discarded.
REQ-023 Mode transitions are as follows; all effects take place on the cycle after the pulse.
- RUN+MODE -> SET_TIME; edit_* loaded from time_*; field_sel=HOUR.
- SET_TIME+MODE -> SET_ALARM; time_load high exactly 1 cycle with load_* = prior edit_*; edit_hour/edit_min loaded from alarm_hour/alarm_min; edit_sec=0; field_sel=HOUR.
- SET_ALARM+MODE -> RUN; alarm_hour/alarm_min = edit_hour/edit_min; no time_load.
REQ-024 SELECT behaviour by mode:
- RUN: toggles alarm_en.
- SET_TIME: cycles field_sel HOUR->MIN->SEC->HOUR.
- SET_ALARM: cycles field_sel HOUR->MIN->HOUR.
REQ-025 INC/DEC SHALL modify only the selected edit register, with modular wrap:
- hour: 23+1=0, 0-1=23.
- min/sec: 59+1=0, 0-1=59.
REQ-026 INC/DEC SHALL be ignored in RUN.
REQ-027 Timeout counter behaviour:
- Cleared on any key pulse, on entry to RUN, and during RUN.
- Otherwise incremented on tick_1hz.
- On reaching TIMEOUT_S in a set mode: return to RUN with no time_load and no alarm update.
REQ-028 If a key pulse and tick_1hz occur in the same cycle, the key SHALL win: the counter clears and the key action applies.
REQ-029 Blink phase SHALL toggle on tick_1hz and clear to 0 (visible) on any key pulse.
REQ-030 blink_hide SHALL be as follows:
- In set modes: the one-hot of field_sel when phase=1, otherwise 0.
- In RUN: always 0.
REQ-031 time_load SHALL never be high in two consecutive cycles.
REQ-032 A MODE pulse SHALL be the only source of time_load.

Reset
REQ-033 On rst high at a clock edge, all outputs SHALL take these values, with rst overriding any coincident key or tick:
- mode=RUN, field_sel=HOUR.
- edit_*=0, load_*=0, time_load=0.
- alarm_hour=0, alarm_min=0, alarm_en=0.
- blink_hide=0; blink phase=0; timeout counter=0.
REQ-034 Reset asserted mid-edit SHALL discard all edit values without issuing time_load.

Verification
REQ-035 The bench SHALL cover these directed scenarios:
- time=12:34:56, MODE, SELECT, INC x26 -> edit_min=0 (wrap); MODE -> time_load 1 cycle, load=12:00:56, mode=SET_ALARM.
- SET_TIME, field HOUR=0, DEC -> edit_hour=23; SELECT x3 -> field_sel back to HOUR.
- SET_ALARM, INC x7, SELECT, DEC -> alarm set 07:59 after MODE; mode=RUN; no time_load.
- SET_TIME, no keys, TIMEOUT_S=30 ticks -> mode=RUN at the 30th tick; time_load never high; key on the 29th tick restarts the count.
- key_pulse=4'b1101 in SET_TIME -> MODE acts only; INC/DEC ignored; RUN+SELECT -> alarm_en toggles 0->1.
- rst asserted while in SET_TIME with a coincident MODE pulse -> all outputs at reset values next cycle; time_load=0.
